// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences one weight-stationary INT8 MAC through weight load, activation stream, drain and result handoff
module mac_seq_ctrl #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_cfg_len,
  input  logic [DATA_W-1:0] i_cfg_weight,
  output logic              o_busy,
  input  logic              i_act_valid,
  input  logic [DATA_W-1:0] i_act_data,
  output logic              o_act_ready,
  output logic [DATA_W-1:0] o_mac_weight_in,
  output logic              o_mac_weight_load,
  output logic              o_mac_acc_clear,
  output logic              o_mac_enable,
  output logic [DATA_W-1:0] o_mac_data_in,
  input  logic [ACC_W-1:0]  i_mac_acc_out,
  output logic              o_res_valid,
  output logic [ACC_W-1:0]  o_res_data,
  input  logic              i_res_ready
);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;
  state_t            r_state, w_next;
  logic [LEN_W-1:0]  r_len, r_cnt;
  logic [DATA_W-1:0] r_weight;
  logic [ACC_W-1:0]  r_res;
  logic              w_beat, w_last;
  assign w_beat = (r_state == RUN) && i_act_valid;
  assign w_last = r_cnt == r_len - 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_len    <= '0;
      r_cnt    <= '0;
      r_weight <= '0;
      r_res    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && i_start) begin
        r_len    <= i_cfg_len;
        r_weight <= i_cfg_weight;
      end
      if (r_state == LOAD) r_cnt <= '0;
      else if (w_beat && !w_last) r_cnt <= r_cnt + 1'b1;
      // the MAC updated on the last beat's edge, so its output is final here
      if (r_state == DRAIN) r_res <= i_mac_acc_out;
    end
  end
  always_comb begin
    w_next            = r_state;
    o_busy            = r_state != IDLE;
    o_act_ready       = r_state == RUN;
    o_mac_weight_load = r_state == LOAD;
    o_mac_acc_clear   = r_state == LOAD;
    o_mac_enable      = w_beat;
    o_res_valid       = r_state == DONE;
    case (r_state)
      IDLE:    w_next = i_start ? LOAD : IDLE;
      LOAD:    w_next = (r_len != '0) ? RUN : DRAIN;
      RUN:     w_next = (w_beat && w_last) ? DRAIN : RUN;
      DRAIN:   w_next = DONE;
      DONE:    w_next = i_res_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  assign o_mac_weight_in = r_weight;
  assign o_mac_data_in   = i_act_data;
  assign o_res_data      = r_res;
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: table-driven jobs against a behavioural INT8 MAC, plus stall, hold and mid-job reset sequences
module tb_mac_seq_ctrl;
  logic        clk = 0, rst_n = 0;
  logic        i_start = 0, i_act_valid = 0, i_res_ready = 1;
  logic [15:0] i_cfg_len = '0;
  logic [7:0]  i_cfg_weight = '0, i_act_data = '0;
  logic        o_busy, o_act_ready, o_mac_weight_load, o_mac_acc_clear, o_mac_enable, o_res_valid;
  logic [7:0]  o_mac_weight_in, o_mac_data_in;
  logic [31:0] o_res_data;
  logic signed [31:0] mac_acc = 0;
  logic signed [7:0]  mac_w = 0;
  int n_cmp = 0, n_bad = 0;
  int en_cnt = 0, ld_cnt = 0, clr_cnt = 0, rdy_cnt = 0;
  typedef struct {
    logic [7:0]      w;
    logic [15:0]     len;
    logic [3:0][7:0] acts;
    int              gap;
    int              hold;
    logic [31:0]     exp;
    int              lat;
  } vec_t;
  vec_t vecs[7];
  mac_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_cfg_len(i_cfg_len), .i_cfg_weight(i_cfg_weight),
    .o_busy(o_busy), .i_act_valid(i_act_valid), .i_act_data(i_act_data), .o_act_ready(o_act_ready),
    .o_mac_weight_in(o_mac_weight_in), .o_mac_weight_load(o_mac_weight_load),
    .o_mac_acc_clear(o_mac_acc_clear), .o_mac_enable(o_mac_enable), .o_mac_data_in(o_mac_data_in),
    .i_mac_acc_out(mac_acc), .o_res_valid(o_res_valid), .o_res_data(o_res_data), .i_res_ready(i_res_ready)
  );
  always #5 clk = ~clk;
  // weight-stationary MAC: INT8 x INT8 sign-extended into a wrapping INT32 accumulator
  always @(posedge clk) begin
    if (o_mac_weight_load) mac_w <= o_mac_weight_in;
    if (o_mac_acc_clear) mac_acc <= 0;
    else if (o_mac_enable) mac_acc <= mac_acc + $signed(o_mac_data_in) * mac_w;
    if (o_mac_enable) en_cnt <= en_cnt + 1;
    if (o_mac_weight_load) ld_cnt <= ld_cnt + 1;
    if (o_mac_acc_clear) clr_cnt <= clr_cnt + 1;
    if (o_act_ready) rdy_cnt <= rdy_cnt + 1;
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask
  task automatic run_job(input vec_t v);
    int   edges, k, g, en0, ld0, clr0, rdy0;
    logic acc;
    k = 0;
    g = 0;
    i_res_ready = (v.hold == 0);
    @(posedge clk); #1;
    i_start = 1;
    i_cfg_len = v.len;
    i_cfg_weight = v.w;
    en0 = en_cnt; ld0 = ld_cnt; clr0 = clr_cnt; rdy0 = rdy_cnt;
    @(posedge clk); #1;
    edges = 1;
    i_start = 0;
    check("busy_after_start", {31'd0, o_busy}, 1);
    while (!o_res_valid && edges < 300) begin
      i_act_valid = (k < int'(v.len)) && (g == 0);
      i_act_data = v.acts[k[1:0]];
      acc = i_act_valid && o_act_ready;
      @(posedge clk); #1;
      edges++;
      if (acc) begin
        k++;
        g = v.gap;
      end else if (g > 0) g--;
    end
    i_act_valid = 0;
    check("latency", edges, v.lat);
    check("res_data", o_res_data, v.exp);
    check("enable_pulses", en_cnt - en0, {16'd0, v.len});
    check("weight_load_pulses", ld_cnt - ld0, 1);
    check("acc_clear_pulses", clr_cnt - clr0, 1);
    check("ready_cycles", rdy_cnt - rdy0, v.lat - 3);
    check("weight_in", {24'd0, o_mac_weight_in}, {24'd0, v.w});
    for (int c = 0; c < v.hold; c++) begin
      i_start = 1;
      @(posedge clk); #1;
      check("hold_valid", {31'd0, o_res_valid}, 1);
      check("hold_data", o_res_data, v.exp);
      check("hold_busy", {31'd0, o_busy}, 1);
    end
    i_start = 0;
    i_res_ready = 1;
    @(posedge clk); #1;
    check("idle_after_done", {30'd0, o_busy, o_res_valid}, 0);
  endtask
  initial begin
    vecs[0] = '{w: 8'd3,    len: 16'd4, acts: {8'd4, 8'd3, 8'd2, 8'd1},         gap: 0, hold: 0, exp: 32'd30,       lat: 7};
    vecs[1] = '{w: 8'h80,   len: 16'd2, acts: {8'd0, 8'd0, 8'h80, 8'h80},       gap: 0, hold: 0, exp: 32'd32768,    lat: 5};
    vecs[2] = '{w: 8'd5,    len: 16'd3, acts: {8'd0, 8'hFD, 8'hFE, 8'hFF},      gap: 0, hold: 0, exp: 32'hFFFFFFE2, lat: 6};
    vecs[3] = '{w: 8'd5,    len: 16'd3, acts: {8'd0, 8'hFD, 8'hFE, 8'hFF},      gap: 2, hold: 0, exp: 32'hFFFFFFE2, lat: 10};
    vecs[4] = '{w: 8'd7,    len: 16'd0, acts: '0,                               gap: 0, hold: 2, exp: 32'd0,        lat: 3};
    vecs[5] = '{w: 8'hFF,   len: 16'd1, acts: {8'd0, 8'd0, 8'd0, 8'd100},       gap: 0, hold: 5, exp: 32'hFFFFFF9C, lat: 4};
    vecs[6] = '{w: 8'd2,    len: 16'd2, acts: {8'd0, 8'd0, 8'd1, 8'd1},         gap: 0, hold: 0, exp: 32'd4,        lat: 5};
    i_act_data = 8'h5A;
    #12;
    check("rst_busy", {31'd0, o_busy}, 0);
    check("rst_strobes", {28'd0, o_act_ready, o_mac_weight_load, o_mac_acc_clear, o_mac_enable}, 0);
    check("rst_res", {31'd0, o_res_valid}, 0);
    check("rst_res_data", o_res_data, 0);
    check("rst_weight_in", {24'd0, o_mac_weight_in}, 0);
    check("data_passthru", {24'd0, o_mac_data_in}, 32'h5A);
    rst_n = 1;
    for (int i = 0; i < 7; i++) run_job(vecs[i]);
    @(posedge clk); #1;
    i_start = 1;
    i_cfg_len = 16'd4;
    i_cfg_weight = 8'd3;
    @(posedge clk); #1;
    i_start = 0;
    i_act_valid = 1;
    i_act_data = 8'd1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_act_data = 8'd2;
    @(posedge clk); #1;
    check("mid_run_busy", {31'd0, o_act_ready}, 1);
    rst_n = 0;
    #1;
    check("arst_busy", {31'd0, o_busy}, 0);
    check("arst_strobes", {28'd0, o_act_ready, o_mac_weight_load, o_mac_acc_clear, o_mac_enable}, 0);
    check("arst_res", {31'd0, o_res_valid}, 0);
    check("arst_res_data", o_res_data, 0);
    check("arst_weight_in", {24'd0, o_mac_weight_in}, 0);
    i_act_valid = 0;
    @(posedge clk); #1;
    rst_n = 1;
    run_job('{w: 8'd1, len: 16'd2, acts: {8'd0, 8'd0, 8'd1, 8'd1}, gap: 0, hold: 0, exp: 32'd2, lat: 5});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
